// File: rtl/ram_access_arbiter.sv
// Two-master round-robin arbiter and access sequencer for a single-port synchronous RAM
// with a shared tri-state data bus; read data returns to the owning master with a one-cycle valid pulse.
module ram_access_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data_bus,
  output logic                  ram_chip_select,
  output logic                  ram_write_enable,
  output logic                  ram_output_enable
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                  m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;

  logic winner;
  logic grant_any;
  logic sel_we;

  // On a tie the master that did not win last time gets the slot.
  always_comb begin
    winner    = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    grant_any = (state_q == IDLE) && (m0_req || m1_req);
    m0_gnt    = grant_any && !winner;
    m1_gnt    = grant_any && winner;
    sel_we    = winner ? m1_we : m0_we;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d      = winner;
          last_grant_d = winner;
          addr_d       = winner ? m1_addr : m0_addr;
          wdata_d      = winner ? m1_wdata : m0_wdata;
          state_d      = sel_we ? WRITE : RD_ADDR;
        end
      end
      WRITE:   state_d = IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        state_d = IDLE;
        if (owner_q) begin
          m1_rdata_d  = ram_data_bus;
          m1_rvalid_d = 1'b1;
        end else begin
          m0_rdata_d  = ram_data_bus;
          m0_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
    end
  end

  // RAM pins decode from registered state only, so the bus is driven solely in WRITE.
  assign ram_address       = addr_q;
  assign ram_chip_select   = (state_q != IDLE);
  assign ram_write_enable  = (state_q == WRITE);
  assign ram_output_enable = (state_q == RD_DATA);
  assign ram_data_bus      = (state_q == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed vector table, hand sequences for reset corners,
// then randomized traffic checked against a transaction-level reference model.
module tb_ram_access_arbiter;

  typedef struct {
    bit          rst_n;
    bit          r0;
    bit          w0;
    logic [3:0]  a0;
    logic [31:0] d0;
    bit          r1;
    bit          w1;
    logic [3:0]  a1;
    logic [31:0] d1;
  } in_t;

  typedef struct {
    bit          g0;
    bit          g1;
    bit          v0;
    bit          v1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    bit          cs;
    bit          we;
    bit          oe;
  } exp_t;

  typedef struct {
    in_t  i;
    bit   chk;
    exp_t e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_address;
  wire  [31:0] ram_data_bus;
  logic        ram_chip_select, ram_write_enable, ram_output_enable;

  ram_access_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_address(ram_address), .ram_data_bus(ram_data_bus),
    .ram_chip_select(ram_chip_select), .ram_write_enable(ram_write_enable),
    .ram_output_enable(ram_output_enable)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Single-port synchronous RAM: write or load output buffer on the edge, drive bus while OE.
  logic [31:0] ram_mem [16];
  logic [31:0] ram_obuf;
  bit          ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 16; k++) ram_mem[k] <= 32'h11 * k;
    end else if (ram_chip_select) begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_bus;
      else                  ram_obuf <= ram_mem[ram_address];
    end
  end

  assign ram_data_bus = (ram_chip_select && ram_output_enable && !ram_write_enable) ? ram_obuf : 32'hzzzz_zzzz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level reference: an accepted op at cycle T occupies T+1 (write) or T+1..T+2 (read).
  logic [31:0] ref_mem [16];
  bit          mvalid = 0;
  int          busy_until = 0;
  int          op_t = 0;
  bit          op_we = 0, op_owner = 0, last = 1;
  logic [3:0]  op_addr = 0;
  logic [31:0] op_wdata = 0;
  logic [31:0] exp_rd [2];
  bit          exp_rv [2];
  bit          eg0 = 0, eg1 = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  task automatic modelCheck(input in_t i);
    bit idle, win, wr, rdd;
    if (!mvalid) begin
      eg0 = 0;
      eg1 = 0;
      return;
    end
    idle = (cyc >= busy_until);
    win  = (i.r0 && i.r1) ? !last : i.r1;
    eg0  = idle && i.r0 && !win;
    eg1  = idle && i.r1 && win;
    wr   = !idle && op_we;
    rdd  = !idle && !op_we && (cyc == op_t + 2);
    checkOutput("m0_gnt", m0_gnt, eg0);
    checkOutput("m1_gnt", m1_gnt, eg1);
    checkOutput("m0_rvalid", m0_rvalid, exp_rv[0]);
    checkOutput("m1_rvalid", m1_rvalid, exp_rv[1]);
    checkOutput("m0_rdata", m0_rdata, exp_rd[0]);
    checkOutput("m1_rdata", m1_rdata, exp_rd[1]);
    checkOutput("ram_cs", ram_chip_select, !idle);
    checkOutput("ram_we", ram_write_enable, wr);
    checkOutput("ram_oe", ram_output_enable, rdd);
    checkOutput("ram_addr", ram_address, op_addr);
    if (ram_write_enable && ram_output_enable) checkOutput("we_oe_exclusive", 1, 0);
    if (wr)  checkOutput("bus_write", ram_data_bus, op_wdata);
    if (rdd) checkOutput("bus_read", ram_data_bus, ref_mem[op_addr]);
  endtask

  task automatic modelAdvance(input in_t i);
    bit idle;
    idle = (cyc >= busy_until);
    exp_rv[0] = 0;
    exp_rv[1] = 0;
    if (!i.rst_n) begin
      mvalid     = 1;
      busy_until = cyc + 1;
      last       = 1;
      exp_rd[0]  = 0;
      exp_rd[1]  = 0;
      op_addr    = 0;
      op_wdata   = 0;
      op_owner   = 0;
      op_we      = 0;
      return;
    end
    if (!mvalid) return;
    if (!idle && !op_we && (cyc == op_t + 2)) begin
      exp_rv[op_owner] = 1;
      exp_rd[op_owner] = ref_mem[op_addr];
    end
    if (eg0 || eg1) begin
      op_owner   = eg1;
      op_we      = eg1 ? i.w1 : i.w0;
      op_addr    = eg1 ? i.a1 : i.a0;
      op_wdata   = eg1 ? i.d1 : i.d0;
      op_t       = cyc;
      last       = op_owner;
      busy_until = cyc + (op_we ? 2 : 3);
      if (op_we) ref_mem[op_addr] = op_wdata;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n = v.i.rst_n;
    m0_req = v.i.r0; m0_we = v.i.w0; m0_addr = v.i.a0; m0_wdata = v.i.d0;
    m1_req = v.i.r1; m1_we = v.i.w1; m1_addr = v.i.a1; m1_wdata = v.i.d1;
    @(negedge clk);
    modelCheck(v.i);
    if (v.chk) begin
      checkOutput("tbl_m0_gnt", m0_gnt, v.e.g0);
      checkOutput("tbl_m1_gnt", m1_gnt, v.e.g1);
      checkOutput("tbl_m0_rvalid", m0_rvalid, v.e.v0);
      checkOutput("tbl_m1_rvalid", m1_rvalid, v.e.v1);
      checkOutput("tbl_m0_rdata", m0_rdata, v.e.rd0);
      checkOutput("tbl_m1_rdata", m1_rdata, v.e.rd1);
      checkOutput("tbl_cs", ram_chip_select, v.e.cs);
      checkOutput("tbl_we", ram_write_enable, v.e.we);
      checkOutput("tbl_oe", ram_output_enable, v.e.oe);
    end
    modelAdvance(v.i);
    @(posedge clk);
    #1;
    ram_init = 0;
    cyc++;
  endtask

  function automatic in_t inp(bit rst, bit r0, bit w0, logic [3:0] a0, logic [31:0] d0,
                              bit r1, bit w1, logic [3:0] a1, logic [31:0] d1);
    in_t i;
    i.rst_n = rst; i.r0 = r0; i.w0 = w0; i.a0 = a0; i.d0 = d0;
    i.r1 = r1; i.w1 = w1; i.a1 = a1; i.d1 = d1;
    return i;
  endfunction

  function automatic in_t nop(bit rst);
    return inp(rst, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t ex(bit g0, bit g1, bit v0, bit v1, logic [31:0] rd0, logic [31:0] rd1,
                              bit cs, bit we, bit oe);
    exp_t e;
    e.g0 = g0; e.g1 = g1; e.v0 = v0; e.v1 = v1; e.rd0 = rd0; e.rd1 = rd1;
    e.cs = cs; e.we = we; e.oe = oe;
    return e;
  endfunction

  function automatic vec_t mkv(in_t i, bit chk, exp_t e);
    vec_t v;
    v.i = i; v.chk = chk; v.e = e;
    return v;
  endfunction

  vec_t tbl[$];
  in_t  tie;
  bit          pend [2];
  bit          pwe [2];
  logic [3:0]  paddr [2];
  logic [31:0] pdata [2];

  initial begin
    ram_init = 1;
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'h11 * k;
    exp_rd[0] = 0; exp_rd[1] = 0;
    exp_rv[0] = 0; exp_rv[1] = 0;
    tie = inp(1, 1, 0, 4'd1, 0, 1, 0, 4'd2, 0);

    // Reset, m0 write/read of addr 3, then a fresh reset and a tie-driven alternation of reads.
    tbl.push_back(mkv(nop(0), 0, ex(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(nop(0), 1, ex(0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(inp(1,1,1,4'd3,32'hDEADBEEF,0,0,0,0), 1, ex(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,1,0)));
    tbl.push_back(mkv(inp(1,1,0,4'd3,0,0,0,0,0), 1, ex(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,0,0)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,0,1)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,1,0,32'hDEADBEEF,0,0,0,0)));
    tbl.push_back(mkv(nop(0), 1, ex(0,0,0,0,32'hDEADBEEF,0,0,0,0)));
    tbl.push_back(mkv(tie, 1, ex(1,0,0,0,0,0,0,0,0)));
    tbl.push_back(mkv(tie, 1, ex(0,0,0,0,0,0,1,0,0)));
    tbl.push_back(mkv(tie, 1, ex(0,0,0,0,0,0,1,0,1)));
    tbl.push_back(mkv(tie, 1, ex(0,1,1,0,32'h11,0,0,0,0)));
    tbl.push_back(mkv(tie, 1, ex(0,0,0,0,32'h11,0,1,0,0)));
    tbl.push_back(mkv(tie, 1, ex(0,0,0,0,32'h11,0,1,0,1)));
    tbl.push_back(mkv(tie, 1, ex(1,0,0,1,32'h11,32'h22,0,0,0)));
    tbl.push_back(mkv(inp(1,0,0,0,0,1,0,4'd2,0), 1, ex(0,0,0,0,32'h11,32'h22,1,0,0)));
    tbl.push_back(mkv(inp(1,0,0,0,0,1,0,4'd2,0), 1, ex(0,0,0,0,32'h11,32'h22,1,0,1)));
    tbl.push_back(mkv(inp(1,0,0,0,0,1,0,4'd2,0), 1, ex(0,1,1,0,32'h11,32'h22,0,0,0)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,0,32'h11,32'h22,1,0,0)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,0,32'h11,32'h22,1,0,1)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,1,32'h11,32'h22,0,0,0)));
    tbl.push_back(mkv(nop(1), 1, ex(0,0,0,0,32'h11,32'h22,0,0,0)));
    for (int k = 0; k < tbl.size(); k++) applyStimulus(tbl[k]);

    // Write data changed after the grant must not reach the RAM.
    applyStimulus(mkv(inp(1,0,0,0,0,1,1,4'd15,32'h0), 1, ex(0,1,0,0,32'h11,32'h22,0,0,0)));
    applyStimulus(mkv(inp(1,0,0,0,0,0,1,4'd15,32'hFFFFFFFF), 1, ex(0,0,0,0,32'h11,32'h22,1,1,0)));
    applyStimulus(mkv(inp(1,0,0,0,0,1,0,4'd15,0), 1, ex(0,1,0,0,32'h11,32'h22,0,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,32'h11,32'h22,1,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,32'h11,32'h22,1,0,1)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,1,32'h11,32'h0,0,0,0)));

    // Reset in the RD_DATA cycle of an m0 read: no rvalid, rdata cleared, next tie to m0.
    applyStimulus(mkv(inp(1,1,0,4'd3,0,0,0,0,0), 1, ex(1,0,0,0,32'h11,0,0,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,32'h11,0,1,0,0)));
    applyStimulus(mkv(nop(0), 1, ex(0,0,0,0,32'h11,0,1,0,1)));
    applyStimulus(mkv(tie, 1, ex(1,0,0,0,0,0,0,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,0,1)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,1,0,32'h11,0,0,0,0)));

    // Reset during a WRITE cycle still commits the write.
    applyStimulus(mkv(inp(1,1,1,4'd5,32'hA5A5A5A5,0,0,0,0), 1, ex(1,0,0,0,32'h11,0,0,0,0)));
    applyStimulus(mkv(nop(0), 1, ex(0,0,0,0,32'h11,0,1,1,0)));
    applyStimulus(mkv(inp(1,1,0,4'd5,0,0,0,0,0), 1, ex(1,0,0,0,0,0,0,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,0,0)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,0,0,0,0,1,0,1)));
    applyStimulus(mkv(nop(1), 1, ex(0,0,1,0,32'hA5A5A5A5,0,0,0,0)));

    // Random traffic: each master holds a request until the model grants it.
    for (int m = 0; m < 2; m++) pend[m] = 0;
    for (int n = 0; n < 1500; n++) begin
      in_t ri;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m]  = 1;
          pwe[m]   = 1'($urandom_range(0, 1));
          paddr[m] = 4'($urandom_range(0, 15));
          pdata[m] = $urandom;
        end
      end
      ri = inp(($urandom_range(0, 99) != 0),
               pend[0], pwe[0], pend[0] ? paddr[0] : 4'($urandom_range(0, 15)), pend[0] ? pdata[0] : $urandom,
               pend[1], pwe[1], pend[1] ? paddr[1] : 4'($urandom_range(0, 15)), pend[1] ? pdata[1] : $urandom);
      applyStimulus(mkv(ri, 0, ex(0,0,0,0,0,0,0,0,0)));
      if (ri.rst_n && eg0) pend[0] = 0;
      if (ri.rst_n && eg1) pend[1] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
